// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - valid/ready FIFO controller driving a single-port RAM with a 1-entry output register
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_write_enable,
    output logic                  ram_read_enable,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = ADDR_WIDTH'(1);

    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_WAIT = 1'b1;

    // prio_q holds the winner of the last contention; the other side wins the next one
    localparam logic [0:0] PRIO_WRITE = 1'b0;
    localparam logic [0:0] PRIO_READ  = 1'b1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_cnt_q, ram_cnt_d;
    logic [0:0]            rd_state_q, rd_state_d;
    logic [0:0]            prio_q, prio_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic rd_inflight;
    logic wr_req;
    logic rd_req;
    logic wr_grant;
    logic rd_grant;

    always_comb begin
        full        = (ram_cnt_q == CNT_DEPTH);
        rd_inflight = (rd_state_q == RD_WAIT);
        wr_req      = in_valid && !full;
        rd_req      = (ram_cnt_q != '0) && !rd_inflight && (!out_valid_q || out_ready);
        // flush drops any push, so it must not be acknowledged
        in_ready    = !full && !(rd_req && prio_q == PRIO_WRITE) && !flush;
        wr_grant    = in_valid && in_ready;
        rd_grant    = rd_req && !wr_grant && !flush;

        ram_write_enable = wr_grant;
        ram_read_enable  = rd_grant;
        ram_address      = rd_grant ? rd_ptr_q : wr_ptr_q;
        ram_data_in      = wr_grant ? in_data : '0;

        count     = ram_cnt_q + {{ADDR_WIDTH{1'b0}}, rd_inflight} + {{ADDR_WIDTH{1'b0}}, out_valid_q};
        empty     = (count == '0);
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        rd_state_d  = rd_state_q;
        prio_d      = prio_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (wr_grant) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_grant) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr_grant && !rd_grant) begin
            ram_cnt_d = ram_cnt_q + CNT_ONE;
        end else if (rd_grant && !wr_grant) begin
            ram_cnt_d = ram_cnt_q - CNT_ONE;
        end

        if (wr_req && rd_req) begin
            prio_d = wr_grant ? PRIO_WRITE : PRIO_READ;
        end

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // a read is only issued when the output register will be free on its return
        case (rd_state_q)
            RD_IDLE: begin
                if (rd_grant) begin
                    rd_state_d = RD_WAIT;
                end
            end
            default: begin
                rd_state_d  = RD_IDLE;
                out_data_d  = ram_data_out;
                out_valid_d = 1'b1;
            end
        endcase

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            ram_cnt_d   = '0;
            rd_state_d  = RD_IDLE;
            prio_d      = PRIO_READ;
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            rd_state_q  <= RD_IDLE;
            prio_q      <= PRIO_READ;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            rd_state_q  <= rd_state_d;
            prio_q      <= prio_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
